// File: rtl/rf_ctrl_pkg.sv
// Shared types for the register-file write-port controller: write request
// record, grant encoding and register-file geometry.
package rf_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int WB_XLEN    = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_XLEN-1:0]    data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CORE,
    GNT_ACC
  } grant_e;

endpackage

// File: rtl/wb_fifo.sv
// Show-ahead FIFO of pending accelerator writebacks; the head entry is
// visible combinationally so the arbiter can grant and pop it in one cycle.
module wb_fifo
  import rf_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  wb_req_t                  push_data_i,
  input  logic                     pop_i,
  output wb_req_t                  head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t        mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q, rd_ptr_q;
  logic           push_ok, pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign empty_o = (count_o == '0);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between core writeback and
// buffered accelerator results, and tracks registers still owed by the accelerator.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_wb_valid,
  input  logic [REG_ADDR_W-1:0] core_wb_rd,
  input  logic [XLEN-1:0]       core_wb_data,
  output logic                  core_stall,
  input  logic                  acc_rsp_valid,
  input  logic [REG_ADDR_W-1:0] acc_rsp_rd,
  input  logic [XLEN-1:0]       acc_rsp_data,
  output logic                  acc_rsp_ready,
  input  logic                  acc_issue_valid,
  input  logic [REG_ADDR_W-1:0] acc_issue_rd,
  input  logic [REG_ADDR_W-1:0] chk_rs1,
  input  logic [REG_ADDR_W-1:0] chk_rs2,
  input  logic [REG_ADDR_W-1:0] chk_rd,
  output logic                  hazard,
  output logic                  rf_write_reg,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_data
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  wb_req_t               fifo_head, push_req, win_req;
  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CW-1:0]         fifo_count;
  grant_e                grant;

  logic [SW-1:0]         starve_cnt_q, starve_cnt_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  clr_valid_q, clr_valid_d;
  logic [REG_ADDR_W-1:0] clr_rd_q, clr_rd_d;
  logic                  rf_write_reg_q, rf_write_reg_d;
  logic [REG_ADDR_W-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]       rf_data_q, rf_data_d;

  assign push_req      = '{rd: acc_rsp_rd, data: acc_rsp_data};
  assign acc_rsp_ready = !reset && !fifo_full;
  assign fifo_push     = acc_rsp_valid && acc_rsp_ready;
  assign fifo_pop      = (grant == GNT_ACC);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i (push_req),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_comb begin
    grant = GNT_NONE;
    if (!reset) begin
      if (!fifo_empty && (!core_wb_valid || fifo_full || starve_cnt_q == SW'(STARVE_MAX)))
        grant = GNT_ACC;
      else if (core_wb_valid)
        grant = GNT_CORE;
    end
  end

  assign core_stall = core_wb_valid && (grant == GNT_ACC);
  assign win_req    = (grant == GNT_ACC) ? fifo_head : '{rd: core_wb_rd, data: core_wb_data};

  always_comb begin
    starve_cnt_d   = starve_cnt_q;
    busy_d         = busy_q;
    clr_valid_d    = (grant == GNT_ACC);
    clr_rd_d       = fifo_head.rd;
    rf_write_reg_d = (grant != GNT_NONE) && (win_req.rd != '0);
    rf_rd_d        = rf_rd_q;
    rf_data_d      = rf_data_q;

    if (fifo_empty || grant == GNT_ACC)
      starve_cnt_d = '0;
    else if (grant == GNT_CORE && starve_cnt_q != SW'(STARVE_MAX))
      starve_cnt_d = starve_cnt_q + SW'(1);

    if (grant != GNT_NONE) begin
      rf_rd_d   = win_req.rd;
      rf_data_d = win_req.data;
    end

    // Clear lands on the same edge as the RF write; a fresh issue overrides it.
    if (clr_valid_q)
      busy_d[clr_rd_q] = 1'b0;
    if (acc_issue_valid && acc_issue_rd != '0)
      busy_d[acc_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q   <= '0;
      busy_q         <= '0;
      clr_valid_q    <= 1'b0;
      clr_rd_q       <= '0;
      rf_write_reg_q <= 1'b0;
      rf_rd_q        <= '0;
      rf_data_q      <= '0;
    end else begin
      starve_cnt_q   <= starve_cnt_d;
      busy_q         <= busy_d;
      clr_valid_q    <= clr_valid_d;
      clr_rd_q       <= clr_rd_d;
      rf_write_reg_q <= rf_write_reg_d;
      rf_rd_q        <= rf_rd_d;
      rf_data_q      <= rf_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (fifo_count <= CW'(DEPTH));
  end

  assign hazard = (chk_rs1 != '0 && busy_q[chk_rs1]) ||
                  (chk_rs2 != '0 && busy_q[chk_rs2]) ||
                  (chk_rd  != '0 && busy_q[chk_rd]);

  assign rf_write_reg = rf_write_reg_q;
  assign rf_rd        = rf_rd_q;
  assign rf_data      = rf_data_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a vector table for single-cycle behaviour
// plus hand sequences for starvation, full FIFO and mid-operation reset.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_wb_valid;
  logic [4:0]  core_wb_rd;
  logic [31:0] core_wb_data;
  logic        core_stall;
  logic        acc_rsp_valid;
  logic [4:0]  acc_rsp_rd;
  logic [31:0] acc_rsp_data;
  logic        acc_rsp_ready;
  logic        acc_issue_valid;
  logic [4:0]  acc_issue_rd;
  logic [4:0]  chk_rs1, chk_rs2, chk_rd;
  logic        hazard;
  logic        rf_write_reg;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .core_wb_valid   (core_wb_valid),
    .core_wb_rd      (core_wb_rd),
    .core_wb_data    (core_wb_data),
    .core_stall      (core_stall),
    .acc_rsp_valid   (acc_rsp_valid),
    .acc_rsp_rd      (acc_rsp_rd),
    .acc_rsp_data    (acc_rsp_data),
    .acc_rsp_ready   (acc_rsp_ready),
    .acc_issue_valid (acc_issue_valid),
    .acc_issue_rd    (acc_issue_rd),
    .chk_rs1         (chk_rs1),
    .chk_rs2         (chk_rs2),
    .chk_rd          (chk_rd),
    .hazard          (hazard),
    .rf_write_reg    (rf_write_reg),
    .rf_rd           (rf_rd),
    .rf_data         (rf_data)
  );

  typedef struct {
    logic        cv;
    logic [4:0]  crd;
    logic [31:0] cdata;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  rs1, rs2, rdc;
    logic        e_stall, e_ready, e_haz;
    logic        e_wr;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic cv, input logic [4:0] crd, input logic [31:0] cdata,
    input logic av, input logic [4:0] ard, input logic [31:0] adata,
    input logic iv, input logic [4:0] ird,
    input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rdc,
    input logic e_stall, input logic e_ready, input logic e_haz,
    input logic e_wr, input logic [4:0] e_rd, input logic [31:0] e_data);
    vec_t v;
    v.cv = cv; v.crd = crd; v.cdata = cdata;
    v.av = av; v.ard = ard; v.adata = adata;
    v.iv = iv; v.ird = ird;
    v.rs1 = rs1; v.rs2 = rs2; v.rdc = rdc;
    v.e_stall = e_stall; v.e_ready = e_ready; v.e_haz = e_haz;
    v.e_wr = e_wr; v.e_rd = e_rd; v.e_data = e_data;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_rf(input string nm, input logic wr, input logic [4:0] rd,
                          input logic [31:0] data);
    chk({nm, ".rf_write_reg"}, 32'(rf_write_reg), 32'(wr));
    if (wr) begin
      chk({nm, ".rf_rd"}, 32'(rf_rd), 32'(rd));
      chk({nm, ".rf_data"}, rf_data, data);
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, return at the falling edge.
  task automatic cyc(input logic cv, input logic [4:0] crd, input logic [31:0] cdata,
                     input logic av, input logic [4:0] ard, input logic [31:0] adata,
                     input logic iv, input logic [4:0] ird);
    @(posedge clk);
    #1;
    core_wb_valid = cv; core_wb_rd = crd; core_wb_data = cdata;
    acc_rsp_valid = av; acc_rsp_rd = ard; acc_rsp_data = adata;
    acc_issue_valid = iv; acc_issue_rd = ird;
    @(negedge clk);
    $display("t=%0t core=%0b/x%0d acc=%0b/x%0d stall=%0b ready=%0b haz=%0b rf=%0b x%0d=0x%0h",
             $time, cv, crd, av, ard, core_stall, acc_rsp_ready, hazard,
             rf_write_reg, rf_rd, rf_data);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0,  1, 5, 32'hDEADBEEF);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 1, 12,  12, 0, 0,  0, 1, 0,  0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   12, 0, 0,  0, 1, 1,  0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 1, 12, 32'h7, 0, 0,  12, 0, 0,  0, 1, 1,  0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   12, 0, 0,  0, 1, 1,  1, 12, 32'h7);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   12, 0, 0,  0, 1, 1,  0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   12, 0, 0,  0, 1, 0,  0, 0, 0);
    vecs[7]  = mk(1, 0, 32'h1234, 0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0,  0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 1, 0, 32'h55, 0, 0,  0, 0, 0,  0, 1, 0,  0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 1, 0,  0, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0,  0, 1, 0,  0, 0, 0);
    vecs[11] = mk(1, 7, 32'hA5A5, 0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0,  1, 7, 32'hA5A5);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 1, 20,  0, 0, 0,  0, 1, 0,  0, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 20, 0,  0, 1, 1,  0, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0,   3, 0, 20,  0, 1, 1,  0, 0, 0);
    vecs[15] = mk(0, 0, 0, 1, 20, 32'h2020, 0, 0,  0, 0, 0,  0, 1, 0,  0, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 1, 0,  1, 20, 32'h2020);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 1, 20,  20, 0, 0,  0, 1, 1,  0, 0, 0);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0,   20, 0, 0,  0, 1, 1,  0, 0, 0);
    vecs[19] = mk(0, 0, 0, 1, 20, 32'h3030, 0, 0,  20, 0, 0,  0, 1, 1,  0, 0, 0);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 0,   20, 0, 0,  0, 1, 1,  1, 20, 32'h3030);
    vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0,   20, 0, 0,  0, 1, 1,  0, 0, 0);
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 0,   20, 0, 0,  0, 1, 0,  0, 0, 0);

    // Reset state, with the core and accelerator both requesting.
    reset = 1'b1;
    core_wb_valid = 1'b1; core_wb_rd = 5'd4; core_wb_data = 32'h1;
    acc_rsp_valid = 1'b1; acc_rsp_rd = 5'd4; acc_rsp_data = 32'h2;
    acc_issue_valid = 1'b0; acc_issue_rd = 5'd0;
    chk_rs1 = 5'd4; chk_rs2 = 5'd0; chk_rd = 5'd0;
    @(posedge clk);
    @(negedge clk);
    chk("rst.core_stall", 32'(core_stall), 32'd0);
    chk("rst.acc_rsp_ready", 32'(acc_rsp_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    core_wb_valid = 1'b0; acc_rsp_valid = 1'b0;
    @(negedge clk);
    chk("rst.rf_write_reg", 32'(rf_write_reg), 32'd0);
    chk("rst.rf_rd", 32'(rf_rd), 32'd0);
    chk("rst.rf_data", rf_data, 32'd0);
    chk("rst.hazard", 32'(hazard), 32'd0);
    chk("rst.ready_after", 32'(acc_rsp_ready), 32'd1);

    // Vector table: combinational outputs this cycle, registered write one cycle later.
    for (int i = 0; i < NV; i++) begin
      chk_rs1 = vecs[i].rs1; chk_rs2 = vecs[i].rs2; chk_rd = vecs[i].rdc;
      cyc(vecs[i].cv, vecs[i].crd, vecs[i].cdata, vecs[i].av, vecs[i].ard, vecs[i].adata,
          vecs[i].iv, vecs[i].ird);
      chk($sformatf("vec%0d.core_stall", i), 32'(core_stall), 32'(vecs[i].e_stall));
      chk($sformatf("vec%0d.acc_rsp_ready", i), 32'(acc_rsp_ready), 32'(vecs[i].e_ready));
      chk($sformatf("vec%0d.hazard", i), 32'(hazard), 32'(vecs[i].e_haz));
      if (i > 0)
        check_rf($sformatf("vec%0d.wb", i - 1), vecs[i-1].e_wr, vecs[i-1].e_rd, vecs[i-1].e_data);
    end
    chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
    idle();
    check_rf($sformatf("vec%0d.wb", NV - 1), vecs[NV-1].e_wr, vecs[NV-1].e_rd, vecs[NV-1].e_data);

    // Starvation: one queued result loses to the core three times, then wins.
    // The second round shows the counter restarted from zero.
    cyc(1, 1, 32'h100, 1, 9, 32'h99, 0, 0); chk("starve0.stall", 32'(core_stall), 0);
    cyc(1, 1, 32'h101, 0, 0, 0, 0, 0);      chk("starve1.stall", 32'(core_stall), 0);
    check_rf("starve0.wb", 1, 1, 32'h100);
    cyc(1, 1, 32'h102, 0, 0, 0, 0, 0);      chk("starve2.stall", 32'(core_stall), 0);
    check_rf("starve1.wb", 1, 1, 32'h101);
    cyc(1, 1, 32'h103, 0, 0, 0, 0, 0);      chk("starve3.stall", 32'(core_stall), 0);
    check_rf("starve2.wb", 1, 1, 32'h102);
    cyc(1, 1, 32'h104, 0, 0, 0, 0, 0);      chk("starve4.stall", 32'(core_stall), 1);
    check_rf("starve3.wb", 1, 1, 32'h103);
    cyc(1, 1, 32'h104, 1, 9, 32'h9A, 0, 0); chk("starve5.stall", 32'(core_stall), 0);
    check_rf("starve4.wb", 1, 9, 32'h99);
    cyc(1, 1, 32'h105, 0, 0, 0, 0, 0);      chk("starve6.stall", 32'(core_stall), 0);
    check_rf("starve5.wb", 1, 1, 32'h104);
    cyc(1, 1, 32'h106, 0, 0, 0, 0, 0);      chk("starve7.stall", 32'(core_stall), 0);
    check_rf("starve6.wb", 1, 1, 32'h105);
    cyc(1, 1, 32'h107, 0, 0, 0, 0, 0);      chk("starve8.stall", 32'(core_stall), 0);
    check_rf("starve7.wb", 1, 1, 32'h106);
    cyc(1, 1, 32'h108, 0, 0, 0, 0, 0);      chk("starve9.stall", 32'(core_stall), 1);
    check_rf("starve8.wb", 1, 1, 32'h107);
    idle();
    check_rf("starve9.wb", 1, 9, 32'h9A);

    // Full FIFO: four pushes while the core writes, then back-pressure.
    for (int k = 0; k < 4; k++) begin
      cyc(1, 21, 32'hC0 + 32'(k), 1, 5'(10 + k), 32'hA0 + 32'(k), 0, 0);
      chk($sformatf("full%0d.ready", k), 32'(acc_rsp_ready), 1);
      chk($sformatf("full%0d.stall", k), 32'(core_stall), 0);
      if (k == 0) check_rf("full.pre", 0, 0, 0);
      else        check_rf($sformatf("full%0d.wb", k - 1), 1, 21, 32'hC0 + 32'(k - 1));
    end
    cyc(1, 21, 32'hC4, 1, 14, 32'hA4, 0, 0);
    chk("full4.ready", 32'(acc_rsp_ready), 0);
    chk("full4.stall", 32'(core_stall), 1);
    check_rf("full3.wb", 1, 21, 32'hC3);
    cyc(1, 21, 32'hC4, 1, 14, 32'hA4, 0, 0);
    chk("full5.ready", 32'(acc_rsp_ready), 1);
    chk("full5.stall", 32'(core_stall), 0);
    check_rf("full4.wb", 1, 10, 32'hA0);
    cyc(1, 21, 32'hC5, 0, 0, 0, 0, 0);
    chk("full6.ready", 32'(acc_rsp_ready), 0);
    chk("full6.stall", 32'(core_stall), 1);
    check_rf("full5.wb", 1, 21, 32'hC4);
    cyc(1, 21, 32'hC5, 0, 0, 0, 0, 0);
    chk("full7.ready", 32'(acc_rsp_ready), 1);
    chk("full7.stall", 32'(core_stall), 0);
    check_rf("full6.wb", 1, 11, 32'hA1);
    idle(); check_rf("full7.wb", 1, 21, 32'hC5);
    idle(); check_rf("drain0.wb", 1, 12, 32'hA2);
    idle(); check_rf("drain1.wb", 1, 13, 32'hA3);
    idle(); check_rf("drain2.wb", 1, 14, 32'hA4);
    idle(); check_rf("drain3.wb", 0, 0, 0);

    // Reset mid-operation: three queued results, x3 and x7 busy.
    cyc(0, 0, 0, 1, 3, 32'h33, 1, 3);
    cyc(1, 22, 32'hD1, 1, 7, 32'h77, 1, 7);
    chk("mid1.stall", 32'(core_stall), 0);
    chk_rs1 = 3; chk_rs2 = 7;
    cyc(1, 22, 32'hD2, 1, 8, 32'h88, 0, 0);
    chk("mid2.hazard", 32'(hazard), 1);
    check_rf("mid1.wb", 1, 22, 32'hD1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    core_wb_data = 32'hD3; acc_rsp_rd = 5'd9; acc_rsp_data = 32'h99;
    @(negedge clk);
    chk("mid.rst.ready", 32'(acc_rsp_ready), 0);
    chk("mid.rst.stall", 32'(core_stall), 0);
    check_rf("mid2.wb", 1, 22, 32'hD2);
    @(posedge clk);
    #1;
    reset = 1'b0;
    core_wb_valid = 0; acc_rsp_valid = 0;
    @(negedge clk);
    chk("mid.post.hazard_x3", 32'(hazard), 0);
    chk_rs1 = 0;
    #1;
    chk("mid.post.hazard_x7", 32'(hazard), 0);
    chk("mid.post.ready", 32'(acc_rsp_ready), 1);
    check_rf("mid.post.cancel", 0, 0, 0);
    chk_rs2 = 0;
    cyc(1, 22, 32'hD5, 0, 0, 0, 0, 0);
    chk("mid.post.stall", 32'(core_stall), 0);
    check_rf("mid.post.empty", 0, 0, 0);
    idle();
    check_rf("mid.post.core", 1, 22, 32'hD5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
